// File: rtl/pixel_pair_fetcher_pkg.sv
// Shared video constants and state type for the frame-buffer pixel fetch path.
// The timing generator uses the same raster size and sync polarity values.
package pixel_pair_fetcher_pkg;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int FRAME_WORDS_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF / 2;

  // Syncs are active-low; the idle level is also the reset value of the outputs.
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_addr_counter.sv
// Frame-memory word address counter: a load to zero for the frame wrap and an
// increment once per consumed pixel pair. The load wins if both are requested.
module fetch_addr_counter #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr = cnt_q;

endmodule

// File: rtl/pixel_pair_fetcher.sv
// Serializes 48-bit pixel pairs from frame memory into a 24-bit RGB stream,
// delaying syncs and display enable by one pixel tick to stay aligned.
module pixel_pair_fetcher
  import pixel_pair_fetcher_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 18
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PIX_EN,
  input  logic [9:0]        H_COUNT,
  input  logic [9:0]        V_COUNT,
  input  logic              DISPLAY_ON,
  input  logic              HSYNC_IN,
  input  logic              VSYNC_IN,
  input  logic [47:0]       MEM_RGB,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [23:0]       RGB,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic              DE,
  output logic              FRAME_START,
  output logic              ALIGN_ERR,
  output fetch_state_e      DBG_STATE
);

  localparam logic [9:0] V_ACTIVE_L = 10'(V_ACTIVE);

  fetch_state_e state_q, state_d;
  logic [23:0]  rgb_q, rgb_d;
  logic [23:0]  pair_q, pair_d;
  logic         hsync_q, hsync_d;
  logic         vsync_q, vsync_d;
  logic         de_q, de_d;
  logic         frame_start_q, frame_start_d;
  logic         align_err_q, align_err_d;
  logic         prev_even_q, prev_even_d;

  logic vblank;
  logic vis_even;
  logic vis_odd;
  logic addr_load;
  logic addr_inc;

  assign vblank   = (V_COUNT >= V_ACTIVE_L);
  assign vis_even = DISPLAY_ON & ~H_COUNT[0];
  assign vis_odd  = DISPLAY_ON & H_COUNT[0];

  // Wrap runs in both states so the first shown frame always starts at word 0.
  assign addr_load = PIX_EN & vblank;
  assign addr_inc  = PIX_EN & (state_q == RUN) & vis_odd;

  always_comb begin
    state_d       = state_q;
    rgb_d         = rgb_q;
    pair_d        = pair_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    frame_start_d = 1'b0;
    align_err_d   = align_err_q;
    prev_even_d   = prev_even_q;
    if (PIX_EN) begin
      hsync_d     = HSYNC_IN;
      vsync_d     = VSYNC_IN;
      prev_even_d = vis_even;
      case (state_q)
        SYNC_WAIT: begin
          rgb_d = '0;
          de_d  = 1'b0;
          if (vblank) begin
            state_d = RUN;
          end
        end
        RUN: begin
          de_d          = DISPLAY_ON;
          frame_start_d = DISPLAY_ON && (H_COUNT == '0) && (V_COUNT == '0);
          if (vis_even) begin
            rgb_d  = MEM_RGB[47:24];
            pair_d = MEM_RGB[23:0];
          end else if (vis_odd) begin
            rgb_d = pair_q;
            // An odd column must directly follow its even partner tick.
            if (!prev_even_q) begin
              align_err_d = 1'b1;
            end
          end else begin
            rgb_d = '0;
          end
        end
        default: state_d = SYNC_WAIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= SYNC_WAIT;
      rgb_q         <= '0;
      pair_q        <= '0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      align_err_q   <= 1'b0;
      prev_even_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rgb_q         <= rgb_d;
      pair_q        <= pair_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      align_err_q   <= align_err_d;
      prev_even_q   <= prev_even_d;
    end
  end

  fetch_addr_counter #(
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk (CLK),
    .rst (RST),
    .load(addr_load),
    .inc (addr_inc),
    .addr(MEM_ADDR)
  );

  assign RGB         = rgb_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign FRAME_START = frame_start_q;
  assign ALIGN_ERR   = align_err_q;
  assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_pixel_pair_fetcher.sv
// Bench for pixel_pair_fetcher on a reduced 16x6 raster: a timing generator
// loop drives ticks, a memory model answers reads, a scoreboard checks outputs.
module tb_pixel_pair_fetcher;
  import pixel_pair_fetcher_pkg::*;

  localparam int H_ACT  = 16;
  localparam int V_ACT  = 6;
  localparam int H_TOT  = 20;
  localparam int V_TOT  = 8;
  localparam int ADDR_W = 18;
  localparam int WORDS  = H_ACT * V_ACT / 2;
  localparam int EW     = 24 + 6 + ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pix_en = 1'b0;
  logic [9:0]        h_count = '0;
  logic [9:0]        v_count = '0;
  logic              display_on = 1'b0;
  logic              hsync_in = 1'b1;
  logic              vsync_in = 1'b1;
  logic [47:0]       mem_rgb = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       rgb;
  logic              hsync, vsync, de, frame_start, align_err;
  fetch_state_e      dbg_state;

  pixel_pair_fetcher #(
    .H_ACTIVE(H_ACT),
    .V_ACTIVE(V_ACT),
    .ADDR_W  (ADDR_W)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .PIX_EN     (pix_en),
    .H_COUNT    (h_count),
    .V_COUNT    (v_count),
    .DISPLAY_ON (display_on),
    .HSYNC_IN   (hsync_in),
    .VSYNC_IN   (vsync_in),
    .MEM_RGB    (mem_rgb),
    .MEM_ADDR   (mem_addr),
    .RGB        (rgb),
    .HSYNC      (hsync),
    .VSYNC      (vsync),
    .DE         (de),
    .FRAME_START(frame_start),
    .ALIGN_ERR  (align_err),
    .DBG_STATE  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [47:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == '0) return {24'hFF0000, 24'h00FF00};
    return {8'hE0, a[15:0], 8'h1F, a[15:0]};
  endfunction

  always @(posedge clk) mem_rgb <= mem_word(mem_addr);

  int fs_seen = 0;
  always @(posedge clk) if (frame_start) fs_seen++;

  // ---------------- scoreboard ----------------
  logic [EW-1:0]     exp_q[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                fs_exp_cnt = 0;
  logic              run_m = 1'b0;
  logic [ADDR_W-1:0] addr_m = '0;
  logic [23:0]       pair_m = '0;
  logic              align_m = 1'b0;
  logic              prev_even_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check_eq("rst_rgb", 32'(rgb), 32'h0);
    check_eq("rst_hsync", 32'(hsync), 32'h1);
    check_eq("rst_vsync", 32'(vsync), 32'h1);
    check_eq("rst_de", 32'(de), 32'h0);
    check_eq("rst_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_fs", 32'(frame_start), 32'h0);
    check_eq("rst_align", 32'(align_err), 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'(SYNC_WAIT));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    pix_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values();
    run_m = 1'b0;
    addr_m = '0;
    pair_m = '0;
    align_m = 1'b0;
    prev_even_m = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic do_tick(input int h, input int v, input logic de_in, input logic hs_in,
                         input logic vs_in, input int gap);
    logic [23:0]   exp_rgb;
    logic          exp_de, exp_fs;
    logic [47:0]   w;
    logic [EW-1:0] e;
    exp_rgb = '0;
    exp_de  = 1'b0;
    exp_fs  = 1'b0;
    if (run_m) begin
      exp_de = de_in;
      if (de_in) begin
        if (h % 2 == 0) begin
          w = mem_word(addr_m);
          exp_rgb = w[47:24];
          pair_m = w[23:0];
        end else begin
          exp_rgb = pair_m;
          if (!prev_even_m) align_m = 1'b1;
        end
      end
      exp_fs = de_in && (h == 0) && (v == 0);
    end
    if (v >= V_ACT) addr_m = '0;
    else if (run_m && de_in && (h % 2 == 1)) addr_m = addr_m + 1'b1;
    prev_even_m = de_in && (h % 2 == 0);
    if (!run_m && v >= V_ACT) run_m = 1'b1;
    if (exp_fs) fs_exp_cnt++;
    exp_q.push_back({exp_rgb, exp_de, hs_in, vs_in, exp_fs, align_m, run_m, addr_m});

    h_count = 10'(h);
    v_count = 10'(v);
    display_on = de_in;
    hsync_in = hs_in;
    vsync_in = vs_in;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    e = exp_q.pop_front();
    check_eq("rgb", 32'(rgb), 32'(e[EW-1 -: 24]));
    check_eq("de", 32'(de), 32'(e[ADDR_W+5]));
    check_eq("hsync", 32'(hsync), 32'(e[ADDR_W+4]));
    check_eq("vsync", 32'(vsync), 32'(e[ADDR_W+3]));
    check_eq("frame_start", 32'(frame_start), 32'(e[ADDR_W+2]));
    check_eq("align_err", 32'(align_err), 32'(e[ADDR_W+1]));
    check_eq("state", 32'(dbg_state), 32'(e[ADDR_W]));
    check_eq("mem_addr", 32'(mem_addr), 32'(e[ADDR_W-1:0]));
    for (int i = 1; i < gap; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_rgb", 32'(rgb), 32'(e[EW-1 -: 24]));
      check_eq("hold_fs", 32'(frame_start), 32'h0);
      check_eq("hold_addr", 32'(mem_addr), 32'(e[ADDR_W-1:0]));
    end
  endtask

  task automatic run_frame(input int gap, input int bad_line, input int rst_v, input int rst_h);
    logic de_in, hs_in, vs_in, was_run;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        if (v == rst_v && h == rst_h) apply_reset();
        de_in = (v < V_ACT) && (h < H_ACT) && !(v == bad_line && h == 0);
        hs_in = !(h >= 17 && h <= 18);
        vs_in = (v != 7);
        was_run = run_m;
        do_tick(h, v, de_in, hs_in, vs_in, gap);
        if (was_run && v == 0 && h == 0) check_eq("first_px0", 32'(rgb), 32'hFF0000);
        if (was_run && v == 0 && h == 1) begin
          check_eq("first_px1", 32'(rgb), 32'h00FF00);
          check_eq("addr_after_col1", 32'(mem_addr), 32'h1);
        end
        if (was_run && v == V_ACT - 1 && h == H_ACT - 1)
          check_eq("addr_frame_end", 32'(mem_addr), 32'(WORDS));
        if (v == V_ACT && h == 0) check_eq("addr_wrap", 32'(mem_addr), 32'h0);
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    apply_reset();
    run_frame(2, -1, -1, -1);  // hidden frame until vertical blank
    run_frame(2, -1, -1, -1);  // first shown frame
    run_frame(4, -1, 2, 7);    // reset inside a visible line
    run_frame(4, -1, -1, -1);
    run_frame(2, 1, -1, -1);   // line 1 starts at an odd column
    check_eq("align_set", 32'(align_err), 32'h1);
    run_frame(2, -1, -1, -1);
    check_eq("align_sticky", 32'(align_err), 32'h1);
    apply_reset();
    check_eq("fs_count", 32'(fs_seen), 32'(fs_exp_cnt));
    check_eq("fs_frames", 32'(fs_exp_cnt), 32'd5);
    check_eq("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
